seg7_scan_mux: RTL and testbench



---
 rtl/seg7_pkg.sv | 25 ++
 rtl/seg7_hex_decode.sv | 15 +
 rtl/seg7_scan_mux.sv | 132 +++++++++++++
 tb/tb_seg7_scan_mux.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for seven-segment display blocks.
//   HEX_SEG     : hex nibble -> active-low segments {g,f,e,d,c,b,a}
//   AN_OFF      : all anodes off (active-low)
//   SEG_OFF     : all cathodes off (active-low)
//   N_DIG       : digits per display
//   presc_width : prescaler width for a given cycles-per-slot divider
package seg7_pkg;

    localparam int         N_DIG   = 8;
    localparam logic [7:0] AN_OFF  = 8'hFF;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Width needed to count 0..div-1; div is at least 2, so this is at least 1.
    function automatic int presc_width(input int div);
        return $clog2(div);
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational hex-to-seven-segment decoder.
//   nibble : 4-bit hex value in
//   seg_n  : 7-bit active-low cathodes out, seg_n[0]=a .. seg_n[6]=g
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = HEX_SEG[nibble];
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: time-multiplexed driver for an 8-digit common-anode display.
//   clk, rst   : clock, synchronous active-high reset
//   digits     : eight hex nibbles, digit k = digits[4k+3:4k], digit 0 rightmost
//   digit_en   : per-digit enable (0 = dark)
//   dp         : per-digit decimal point, active-high
//   load       : one-cycle request to capture digits/digit_en/dp into the shadow set
//   an         : anodes, active-low, an[k] drives digit k
//   seg        : cathodes, active-low, seg[0]=a .. seg[6]=g
//   dp_n       : decimal-point cathode, active-low
//   frame_done : one-cycle pulse after each 8-digit frame
//
// load handshake: load is a fire-and-forget pulse with no ready. A pulse marks
// an update as pending; the live inputs are sampled only at the frame boundary
// edge (or in the boundary cycle itself if load arrives then), so a frame is
// always drawn from one consistent shadow set. Several pulses in one frame
// collapse into a single update.
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV     = 100000,  // cycles per digit slot, >= 2
    parameter int BLANK_CYCLES = 1000     // leading dark cycles per slot, < SCAN_DIV
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] digits,
    input  logic [7:0]  digit_en,
    input  logic [7:0]  dp,
    input  logic        load,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp_n,
    output logic        frame_done
);

    localparam int             PW      = presc_width(SCAN_DIV);
    localparam logic [PW-1:0]  LAST_W  = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0]  BLANK_W = PW'(BLANK_CYCLES);

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    idx_q, idx_d;
    logic          load_pending_q, load_pending_d;
    logic [31:0]   sh_digits_q, sh_digits_d;
    logic [7:0]    sh_en_q, sh_en_d;
    logic [7:0]    sh_dp_q, sh_dp_d;
    logic [7:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_n_q, dp_n_d;
    logic          frame_done_q, frame_done_d;

    logic          presc_last;
    logic          boundary;
    logic          blank_phase;
    logic          lit;
    logic [3:0]    cur_nibble;
    logic [6:0]    cur_seg;

    assign cur_nibble = sh_digits_q[{idx_q, 2'b00} +: 4];

    seg7_hex_decode u_dec (
        .nibble (cur_nibble),
        .seg_n  (cur_seg)
    );

    always_comb begin
        presc_d        = presc_q;
        idx_d          = idx_q;
        load_pending_d = load_pending_q;
        sh_digits_d    = sh_digits_q;
        sh_en_d        = sh_en_q;
        sh_dp_d        = sh_dp_q;
        frame_done_d   = 1'b0;

        presc_last = (presc_q == LAST_W);
        boundary   = presc_last && (idx_q == 3'd7);

        presc_d = presc_last ? '0 : presc_q + 1'b1;
        idx_d   = presc_last ? idx_q + 3'd1 : idx_q;

        if (boundary) begin
            frame_done_d = 1'b1;
            if (load_pending_q || load) begin
                sh_digits_d    = digits;
                sh_en_d        = digit_en;
                sh_dp_d        = dp;
                load_pending_d = 1'b0;
            end
        end else if (load) begin
            load_pending_d = 1'b1;
        end

        // Outputs come from the current slot state, so an and seg always
        // switch on the same edge; the blank window hides the transition.
        blank_phase = (BLANK_CYCLES != 0) && (presc_q < BLANK_W);
        lit         = !blank_phase && sh_en_q[idx_q];

        an_d   = lit ? ~(8'b0000_0001 << idx_q) : AN_OFF;
        seg_d  = lit ? cur_seg : SEG_OFF;
        dp_n_d = lit ? ~sh_dp_q[idx_q] : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q        <= '0;
            idx_q          <= 3'd0;
            load_pending_q <= 1'b0;
            sh_digits_q    <= 32'h0;
            sh_en_q        <= 8'h0;
            sh_dp_q        <= 8'h0;
            an_q           <= AN_OFF;
            seg_q          <= SEG_OFF;
            dp_n_q         <= 1'b1;
            frame_done_q   <= 1'b0;
        end else begin
            presc_q        <= presc_d;
            idx_q          <= idx_d;
            load_pending_q <= load_pending_d;
            sh_digits_q    <= sh_digits_d;
            sh_en_q        <= sh_en_d;
            sh_dp_q        <= sh_dp_d;
            an_q           <= an_d;
            seg_q          <= seg_d;
            dp_n_q         <= dp_n_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp_n       = dp_n_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb_seg7_scan_mux: randomized and directed stimulus for seg7_scan_mux with a
// frame-position reference model feeding an expected queue and a negedge
// monitor that pops and compares every cycle.
module tb_seg7_scan_mux;

    localparam int SCAN_DIV = 8;
    localparam int BLANK    = 2;
    localparam int FRAME    = SCAN_DIV * 8;
    localparam int EW       = 17;  // {an, seg, dp_n, frame_done}

    logic        clk;
    logic        rst;
    logic [31:0] digits;
    logic [7:0]  digit_en;
    logic [7:0]  dp;
    logic        load;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp_n;
    logic        frame_done;

    int n_cmp;
    int n_fail;

    logic [EW-1:0] exp_q[$];

    // Decode table written out independently of the design package.
    logic [6:0] ref_tab [16];

    // Reference model state: position within the frame (slot*SCAN_DIV + phase).
    int          m_pos;
    logic [31:0] m_dig;
    logic [7:0]  m_en;
    logic [7:0]  m_dp;
    bit          m_pend;

    seg7_scan_mux #(
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digits     (digits),
        .digit_en   (digit_en),
        .dp         (dp),
        .load       (load),
        .an         (an),
        .seg        (seg),
        .dp_n       (dp_n),
        .frame_done (frame_done)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        ref_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        m_pos  = 0;
        m_dig  = '0;
        m_en   = '0;
        m_dp   = '0;
        m_pend = 0;
    end

    // ---------------- reference model ----------------
    // Each active edge yields the outputs for the following cycle, derived
    // from the frame position and shadow contents held before that edge.
    always @(posedge clk) begin
        logic [EW-1:0] e;
        int   slot;
        int   ph;
        bit   lit;
        logic [3:0] nib;
        if (rst) begin
            e      = {8'hFF, 7'h7F, 1'b1, 1'b0};
            m_pos  = 0;
            m_dig  = '0;
            m_en   = '0;
            m_dp   = '0;
            m_pend = 0;
        end else begin
            slot = m_pos / SCAN_DIV;
            ph   = m_pos % SCAN_DIV;
            lit  = (ph >= BLANK) && m_en[slot];
            nib  = 4'((m_dig >> (4 * slot)) & 32'hF);
            if (lit)
                e = {~(8'd1 << slot), ref_tab[nib], ~m_dp[slot], 1'b0};
            else
                e = {8'hFF, 7'h7F, 1'b1, 1'b0};
            if (m_pos == FRAME - 1) begin
                e[0] = 1'b1;
                if (m_pend || load) begin
                    m_dig  = digits;
                    m_en   = digit_en;
                    m_dp   = dp;
                    m_pend = 0;
                end
            end else if (load) begin
                m_pend = 1;
            end
            m_pos = (m_pos + 1) % FRAME;
        end
        exp_q.push_back(e);
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        logic [EW-1:0] a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {an, seg, dp_n, frame_done};
            n_cmp++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL outputs t=%0t an=%h seg=%h dp_n=%b fd=%b required an=%h seg=%h dp_n=%b fd=%b",
                         $time, a[16:9], a[8:2], a[1], a[0], e[16:9], e[8:2], e[1], e[0]);
            end
            n_cmp++;
            if ($countones(~an) > 1) begin
                n_fail++;
                $display("FAIL one_anode t=%0t an=%h required at most one low bit", $time, an);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_load(input logic [31:0] d, input logic [7:0] en, input logic [7:0] p);
        digits   = d;
        digit_en = en;
        dp       = p;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    // Returns at a negedge where the upcoming edge sees frame position p.
    task automatic wait_pos(input int p);
        int n;
        n = 0;
        while (m_pos != p && n < 4 * FRAME) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (m_pos != p) begin
            n_fail++;
            $display("FAIL wait_pos timeout pos=%0d required %0d", m_pos, p);
        end
    endtask

    // Counts negedges until frame_done is seen, checks the count.
    task automatic wait_fd(input int expected, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_done !== 1'b1 && n < 4 * FRAME);
        n_cmp++;
        if (n != expected) begin
            n_fail++;
            $display("FAIL %s frame_done after %0d cycles required %0d", name, n, expected);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        rst      = 1'b1;
        digits   = '0;
        digit_en = '0;
        dp       = '0;
        load     = 1'b0;
        cycles(3);

        // Idle after reset: dark display, frame_done every frame.
        rst = 1'b0;
        wait_fd(FRAME, "first_frame_done");
        wait_fd(FRAME, "second_frame_done");

        // Counting pattern, all enabled, dp on digit 0.
        pulse_load(32'h76543210, 8'hFF, 8'h01);
        cycles(2 * FRAME);

        // Load at slot 3, then change digits without load.
        wait_pos(3 * SCAN_DIV);
        pulse_load(32'h89ABCDEF, 8'hFF, 8'h80);
        digits = 32'h13579BDF;
        cycles(FRAME + 10);
        digits = 32'h2468ACE0;
        cycles(FRAME);

        // Three loads with changing digits in one frame.
        wait_pos(SCAN_DIV);
        pulse_load(32'h11111111, 8'hFF, 8'h00);
        cycles(5);
        pulse_load(32'h22222222, 8'hFF, 8'h0F);
        cycles(5);
        pulse_load(32'h33333333, 8'hFF, 8'hF0);
        digits = 32'hC0FFEE42;
        cycles(2 * FRAME);

        // Sparse enables.
        pulse_load(32'hFEDCBA98, 8'b0000_0101, 8'h00);
        cycles(2 * FRAME);

        // Load exactly in the boundary cycle.
        wait_pos(FRAME - 1);
        pulse_load(32'hA5B6C7D8, 8'hFF, 8'h55);
        cycles(FRAME + 5);

        // Randomized traffic.
        for (int i = 0; i < 6 * FRAME; i++) begin
            if ($urandom_range(0, 7) == 0) digits = $urandom;
            if ($urandom_range(0, 15) == 0) digit_en = 8'($urandom);
            if ($urandom_range(0, 15) == 0) dp = 8'($urandom);
            load = ($urandom_range(0, 19) == 0);
            @(negedge clk);
        end
        load = 1'b0;

        // Reset at slot 5, prescaler 4 while lit.
        pulse_load(32'h87654321, 8'hFF, 8'hFF);
        cycles(FRAME);
        wait_pos(5 * SCAN_DIV + 4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_fd(FRAME, "frame_done_after_rst");
        cycles(FRAME);

        cycles(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
